// File: rtl/set_sched.sv
// set_sched: round-robin scheduler that shares one SET engine between requesters A and B.
// Defining SET_SCHED_TIMEOUT_EN builds an abort-on-timeout counter for the WAIT state.
module set_sched #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [23:0] central_a,
    input  logic [23:0] central_b,
    input  logic [11:0] radius_a,
    input  logic [11:0] radius_b,
    input  logic [1:0]  mode_a,
    input  logic [1:0]  mode_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic        done_a,
    output logic        done_b,
    output logic [7:0]  result,
    output logic        err,
    output logic        set_en,
    output logic [23:0] set_central,
    output logic [11:0] set_radius,
    output logic [1:0]  set_mode,
    input  logic        set_busy,
    input  logic        set_valid,
    input  logic [7:0]  set_candidate
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;       // 1: B wins a tie
    logic        win_b_q, win_b_d;   // side of the job in flight
    logic        grant_b;
    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic        done_a_q, done_a_d;
    logic        done_b_q, done_b_d;
    logic        set_en_q, set_en_d;
    logic [7:0]  result_q, result_d;
    logic [23:0] central_q, central_d;
    logic [11:0] radius_q, radius_d;
    logic [1:0]  mode_q, mode_d;

`ifdef SET_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_b_d   = win_b_q;
        grant_b   = 1'b0;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        done_a_d  = 1'b0;
        done_b_d  = 1'b0;
        set_en_d  = 1'b0;
        result_d  = result_q;
        central_d = central_q;
        radius_d  = radius_q;
        mode_d    = mode_q;
`ifdef SET_SCHED_TIMEOUT_EN
        err_d     = err_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if ((req_a || req_b) && !set_busy) begin
                    grant_b   = req_b && (!req_a || ptr_q);
                    win_b_d   = grant_b;
                    ack_a_d   = !grant_b;
                    ack_b_d   = grant_b;
                    set_en_d  = 1'b1;
                    central_d = grant_b ? central_b : central_a;
                    radius_d  = grant_b ? radius_b : radius_a;
                    mode_d    = grant_b ? mode_b : mode_a;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SET_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // A valid on the timeout edge still delivers the engine's answer.
                if (set_valid) begin
                    result_d = set_candidate;
`ifdef SET_SCHED_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    done_a_d = !win_b_q;
                    done_b_d = win_b_q;
                    ptr_d    = !win_b_q;
                    state_d  = RETURN;
                end
`ifdef SET_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    result_d = 8'hFF;
                    err_d    = 1'b1;
                    done_a_d = !win_b_q;
                    done_b_d = win_b_q;
                    ptr_d    = !win_b_q;
                    state_d  = RETURN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RETURN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            win_b_q   <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            set_en_q  <= 1'b0;
            result_q  <= '0;
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
`ifdef SET_SCHED_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_b_q   <= win_b_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            set_en_q  <= set_en_d;
            result_q  <= result_d;
            central_q <= central_d;
            radius_q  <= radius_d;
            mode_q    <= mode_d;
`ifdef SET_SCHED_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign done_a      = done_a_q;
    assign done_b      = done_b_q;
    assign set_en      = set_en_q;
    assign result      = result_q;
    assign set_central = central_q;
    assign set_radius  = radius_q;
    assign set_mode    = mode_q;
`ifdef SET_SCHED_TIMEOUT_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_set_sched.sv
// Bench for set_sched: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_set_sched;

    localparam int TO = 16;

    localparam logic [23:0] CA = 24'h44_00_00;
    localparam logic [11:0] RA = 12'h300;
    localparam logic [1:0]  MA = 2'd0;
    localparam logic [23:0] CB = 24'h12_3456;
    localparam logic [11:0] RB = 12'hABC;
    localparam logic [1:0]  MB = 2'd3;

    logic        clk, rst;
    logic        req_a, req_b;
    logic [23:0] central_a, central_b;
    logic [11:0] radius_a, radius_b;
    logic [1:0]  mode_a, mode_b;
    logic        ack_a, ack_b, done_a, done_b, err, set_en;
    logic [7:0]  result;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy, set_valid;
    logic [7:0]  set_candidate;

    int checks = 0;
    int errors = 0;

    set_sched #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b),
        .central_a(central_a), .central_b(central_b),
        .radius_a(radius_a), .radius_b(radius_b),
        .mode_a(mode_a), .mode_b(mode_b),
        .ack_a(ack_a), .ack_b(ack_b), .done_a(done_a), .done_b(done_b),
        .result(result), .err(err), .set_en(set_en),
        .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
        .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ra, rb, busy, vld;
        logic [7:0] cand;
        logic       ack_a, ack_b, en, dn_a, dn_b;
        logic [7:0] res;
        logic       err;
        int         op;   // expected operands: 0 zero, 1 A's, 2 B's
    } vec_t;

    localparam int NV = 20;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic r, ra, rb, bz, v, input logic [7:0] c,
                                input logic aa, ab, en, da, db,
                                input logic [7:0] res, input logic e, input int op);
        vec_t t;
        t.rst = r; t.ra = ra; t.rb = rb; t.busy = bz; t.vld = v; t.cand = c;
        t.ack_a = aa; t.ack_b = ab; t.en = en; t.dn_a = da; t.dn_b = db;
        t.res = res; t.err = e; t.op = op;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic eaa, eab, een, eda, edb,
                            input logic [7:0] eres, input logic eerr,
                            input logic [23:0] ec, input logic [11:0] er, input logic [1:0] em);
        chk({tag, ".ack_a"},   32'(ack_a),       32'(eaa));
        chk({tag, ".ack_b"},   32'(ack_b),       32'(eab));
        chk({tag, ".set_en"},  32'(set_en),      32'(een));
        chk({tag, ".done_a"},  32'(done_a),      32'(eda));
        chk({tag, ".done_b"},  32'(done_b),      32'(edb));
        chk({tag, ".result"},  32'(result),      32'(eres));
        chk({tag, ".err"},     32'(err),         32'(eerr));
        chk({tag, ".central"}, 32'(set_central), 32'(ec));
        chk({tag, ".radius"},  32'(set_radius),  32'(er));
        chk({tag, ".mode"},    32'(set_mode),    32'(em));
    endtask

    // reference model state (transaction level)
    bit         m_active, m_issue, m_ret, m_side, m_ptr;
    int         m_wait;
    logic       e_aa, e_ab, e_en, e_da, e_db, e_err;
    logic [7:0] e_res;
    logic [23:0] e_c;
    logic [11:0] e_r;
    logic [1:0]  e_m;
    logic        p_ra, p_rb, p_busy, p_vld;
    logic [7:0]  p_cand;
    logic [23:0] p_ca, p_cb;
    logic [11:0] p_rra, p_rrb;
    logic [1:0]  p_ma, p_mb;

    task automatic model_finish(input logic [7:0] r, input logic e);
        e_da = !m_side; e_db = m_side;
        e_res = r; e_err = e;
        m_ptr = !m_side; m_active = 0; m_ret = 1;
    endtask

    initial begin
        int cnt;
        int seen;
        bit eng_out;
        int eng_cd;
        logic [23:0] ec;
        logic [11:0] er;
        logic [1:0]  em;

        rst = 1; req_a = 0; req_b = 0; set_busy = 0; set_valid = 0; set_candidate = 0;
        central_a = CA; radius_a = RA; mode_a = MA;
        central_b = CB; radius_b = RB; mode_b = MB;

        //                 rst ra rb bz v  cand   aa ab en da db res  err op
        tbl[0]  = mk(1, 0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd0,  0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 8'd0,  1, 0, 1, 0, 0, 8'd0,  0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd0,  0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd0,  0, 1);
        tbl[4]  = mk(0, 0, 0, 0, 1, 8'd29, 0, 0, 0, 1, 0, 8'd29, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd29, 0, 1);
        tbl[6]  = mk(1, 0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd0,  0, 0);
        tbl[7]  = mk(0, 1, 1, 0, 0, 8'd0,  1, 0, 1, 0, 0, 8'd0,  0, 1);
        tbl[8]  = mk(0, 1, 1, 0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd0,  0, 1);
        tbl[9]  = mk(0, 1, 1, 0, 1, 8'd1,  0, 0, 0, 1, 0, 8'd1,  0, 1);
        tbl[10] = mk(0, 1, 1, 0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd1,  0, 1);
        tbl[11] = mk(0, 1, 1, 0, 0, 8'd0,  0, 1, 1, 0, 0, 8'd1,  0, 2);
        tbl[12] = mk(0, 1, 1, 0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd1,  0, 2);
        tbl[13] = mk(0, 1, 1, 0, 1, 8'd2,  0, 0, 0, 0, 1, 8'd2,  0, 2);
        tbl[14] = mk(0, 1, 1, 0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd2,  0, 2);
        tbl[15] = mk(0, 1, 1, 0, 0, 8'd0,  1, 0, 1, 0, 0, 8'd2,  0, 1);
        tbl[16] = mk(0, 0, 0, 0, 1, 8'd77, 0, 0, 0, 0, 0, 8'd2,  0, 1);
        tbl[17] = mk(0, 0, 0, 0, 1, 8'd3,  0, 0, 0, 1, 0, 8'd3,  0, 1);
        tbl[18] = mk(0, 0, 0, 0, 1, 8'd99, 0, 0, 0, 0, 0, 8'd3,  0, 1);
        tbl[19] = mk(0, 0, 0, 0, 1, 8'd98, 0, 0, 0, 0, 0, 8'd3,  0, 1);

        tick();
        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; req_a = tbl[i].ra; req_b = tbl[i].rb;
            set_busy = tbl[i].busy; set_valid = tbl[i].vld; set_candidate = tbl[i].cand;
            tick();
            case (tbl[i].op)
                1:       begin ec = CA; er = RA; em = MA; end
                2:       begin ec = CB; er = RB; em = MB; end
                default: begin ec = '0; er = '0; em = '0; end
            endcase
            chk_outs($sformatf("vec%0d", i), tbl[i].ack_a, tbl[i].ack_b, tbl[i].en,
                     tbl[i].dn_a, tbl[i].dn_b, tbl[i].res, tbl[i].err, ec, er, em);
        end
        set_valid = 0;

        // engine busy holds off a waiting request
        req_b = 1; set_busy = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy.ack_b", 32'(ack_b), 32'd0);
            chk("busy.set_en", 32'(set_en), 32'd0);
        end
        set_busy = 0;
        tick();
        chk("busy.grant_ack_b", 32'(ack_b), 32'd1);
        chk("busy.grant_en", 32'(set_en), 32'd1);
        chk("busy.central", 32'(set_central), 32'(CB));
        req_b = 0;
        tick();
        set_valid = 1; set_candidate = 8'd55;
        tick();
        chk("busy.done_b", 32'(done_b), 32'd1);
        chk("busy.result", 32'(result), 32'd55);
        set_valid = 0;
        tick();

        // reset in WAIT discards the job
        req_a = 1;
        tick();
        chk("rstwait.ack_a", 32'(ack_a), 32'd1);
        req_a = 0;
        tick();
        tick();
        rst = 1;
        #1;
        chk_outs("rstwait.async", 0, 0, 0, 0, 0, 8'd0, 0, 24'd0, 12'd0, 2'd0);
        tick();
        rst = 0; set_valid = 1; set_candidate = 8'd66;
        tick();
        chk_outs("rstwait.late_valid", 0, 0, 0, 0, 0, 8'd0, 0, 24'd0, 12'd0, 2'd0);
        set_valid = 0; req_b = 1;
        tick();
        chk("rstwait.ack_b", 32'(ack_b), 32'd1);
        chk("rstwait.central", 32'(set_central), 32'(CB));
        req_b = 0;
        tick();
        set_valid = 1; set_candidate = 8'd7;
        tick();
        chk("rstwait.done_b", 32'(done_b), 32'd1);
        chk("rstwait.result", 32'(result), 32'd7);
        set_valid = 0;
        tick();

`ifdef SET_SCHED_TIMEOUT_EN
        req_a = 1;
        tick();
        chk("to.ack_a", 32'(ack_a), 32'd1);
        req_a = 0;
        cnt = 0; seen = 0;
        while (!seen && cnt < 100) begin
            tick();
            cnt++;
            if (done_a) seen = 1;
        end
        chk("to.latency", 32'(cnt), 32'd17);
        chk("to.result", 32'(result), 32'hFF);
        chk("to.err", 32'(err), 32'd1);
        tick();
        req_b = 1;
        tick();
        chk("to.next_ack_b", 32'(ack_b), 32'd1);
        req_b = 0;
        tick();
        set_valid = 1; set_candidate = 8'd42;
        tick();
        chk("to.next_done_b", 32'(done_b), 32'd1);
        chk("to.next_result", 32'(result), 32'd42);
        chk("to.next_err", 32'(err), 32'd0);
        set_valid = 0;
        tick();
        req_a = 1;
        tick();
        req_a = 0;
        repeat (16) tick();
        set_valid = 1; set_candidate = 8'd88;
        tick();
        chk("to.tie_done_a", 32'(done_a), 32'd1);
        chk("to.tie_result", 32'(result), 32'd88);
        chk("to.tie_err", 32'(err), 32'd0);
        set_valid = 0;
        tick();
`else
        req_a = 1;
        tick();
        chk("nto.ack_a", 32'(ack_a), 32'd1);
        req_a = 0;
        seen = 0;
        repeat (40) begin
            tick();
            if (done_a) seen++;
        end
        chk("nto.no_done", 32'(seen), 32'd0);
        set_valid = 1; set_candidate = 8'd13;
        tick();
        chk("nto.done_a", 32'(done_a), 32'd1);
        chk("nto.result", 32'(result), 32'd13);
        chk("nto.err", 32'(err), 32'd0);
        set_valid = 0;
        tick();
`endif

        // randomized run against the reference model
        rst = 1;
        tick();
        rst = 0; req_a = 0; req_b = 0; set_busy = 0; set_valid = 0;
        m_active = 0; m_issue = 0; m_ret = 0; m_side = 0; m_ptr = 0; m_wait = 0;
        e_res = 0; e_err = 0; e_c = 0; e_r = 0; e_m = 0;
        eng_out = 0; eng_cd = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (req_a && ack_a) req_a = 0;
            else if (!req_a && ($urandom % 4 == 0)) begin
                req_a = 1; central_a = 24'($urandom); radius_a = 12'($urandom); mode_a = 2'($urandom);
            end
            if (req_b && ack_b) req_b = 0;
            else if (!req_b && ($urandom % 4 == 0)) begin
                req_b = 1; central_b = 24'($urandom); radius_b = 12'($urandom); mode_b = 2'($urandom);
            end
            set_busy = ($urandom % 4 == 0);
            if (set_en) begin eng_out = 1; eng_cd = int'($urandom_range(1, 5)); end
            set_valid = 0;
            set_candidate = 8'($urandom);
            if (eng_out) begin
                if (eng_cd == 0) begin set_valid = 1; eng_out = 0; end
                else eng_cd--;
            end else begin
                set_valid = ($urandom % 8 == 0);
            end
            p_ra = req_a; p_rb = req_b; p_busy = set_busy; p_vld = set_valid; p_cand = set_candidate;
            p_ca = central_a; p_cb = central_b; p_rra = radius_a; p_rrb = radius_b;
            p_ma = mode_a; p_mb = mode_b;

            tick();

            e_aa = 0; e_ab = 0; e_en = 0; e_da = 0; e_db = 0;
            if (m_ret) m_ret = 0;
            else if (!m_active) begin
                if ((p_ra || p_rb) && !p_busy) begin
                    m_side = (p_ra && p_rb) ? m_ptr : p_rb;
                    e_aa = !m_side; e_ab = m_side; e_en = 1;
                    e_c = m_side ? p_cb : p_ca;
                    e_r = m_side ? p_rrb : p_rra;
                    e_m = m_side ? p_mb : p_ma;
                    m_active = 1; m_issue = 1;
                end
            end else if (m_issue) begin
                m_issue = 0; m_wait = 0;
            end else if (p_vld) begin
                model_finish(p_cand, 0);
            end else begin
                m_wait++;
`ifdef SET_SCHED_TIMEOUT_EN
                if (m_wait == TO) model_finish(8'hFF, 1);
`endif
            end
            chk_outs($sformatf("rnd%0d", cyc), e_aa, e_ab, e_en, e_da, e_db, e_res, e_err, e_c, e_r, e_m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/set_sched.md
SET_SCHED -- requirements
Module: set_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023, is the cycles spent in WAIT before a job is aborted; used only when SET_SCHED_TIMEOUT_EN is defined.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req_a / req_b  input  1  requester A/B job request, level, held until ack.
REQ-005 central_a / central_b  input  24  {x1,y1,x2,y2,x3,y3}, 4 bits each, sampled at grant.
REQ-006 radius_a / radius_b  input  12  {r1,r2,r3}, 4 bits each, sampled at grant.
REQ-007 mode_a / mode_b  input  2  set-operation mode 0..3, sampled at grant.
REQ-008 ack_a / ack_b  output  1  one-cycle pulse: job accepted, operands captured.
REQ-009 done_a / done_b  output  1  one-cycle pulse: result on result/err is valid for that requester.
REQ-010 result  output  8  count returned by the engine, shared by both requesters.
REQ-011 err  output  1  high with done when the job timed out.
REQ-012 set_en  output  1  one-cycle start pulse to the SET engine.
REQ-013 set_central / set_radius / set_mode  output  24/12/2  latched job operands, held stable from ISSUE through WAIT.
REQ-014 set_busy / set_valid  input  1  engine busy level / engine done pulse.
REQ-015 set_candidate  input  8  engine count, valid while set_valid=1.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RETURN.
REQ-017 All outputs SHALL be registered.
REQ-018 IDLE -> ISSUE at an edge where (req_a|req_b)=1 and set_busy=0.
- On that edge the winner's operands are latched into set_central/set_radius/set_mode.
- ack_<winner>=1 and set_en=1 together for exactly the following cycle.
REQ-019 Arbitration SHALL be round-robin with a 1-bit pointer (reset value: A).
- Only one request high: it wins.
- Both high: the pointer's side wins.
- Pointer moves to the non-served side on entering RETURN.
REQ-020 ISSUE -> WAIT unconditionally after one cycle; set_en SHALL be low in every state other than ISSUE.
REQ-021 WAIT -> RETURN at the edge where set_valid=1.
- set_candidate is captured into result and err=0.
REQ-022 RETURN lasts one cycle, with done_<winner>=1; RETURN -> IDLE.
- result and err hold their values until the next RETURN.
REQ-023 Latency: ack and set_en appear 1 cycle after the accepting edge; done appears 1 cycle after the set_valid edge.
REQ-024 A request still high in the cycle after its ack SHALL be treated as a new job; requesters drop req on seeing ack.
REQ-025 set_valid outside WAIT SHALL be ignored.
REQ-026 While set_busy=1 in IDLE, no grant SHALL be made; requests wait without loss.
REQ-027 Requests arriving in ISSUE/WAIT/RETURN are not acked until the FSM is back in IDLE.
REQ-028 Operands driven to the engine SHALL be bit-exact copies of the granted requester's inputs, with no arithmetic applied.

Reset
REQ-029 rst=1 SHALL immediately return the FSM to IDLE and set the rr pointer to A.
REQ-030 rst=1 SHALL clear every output to 0 (ack_*, done_*, set_en, result, err, set_central, set_radius, set_mode) and clear the timeout counter.
REQ-031 Reset mid-job SHALL discard the job with no done pulse; the first grant after release follows REQ-018 rules.

Configuration
REQ-032 Macro SET_SCHED_TIMEOUT_EN defined:
- A counter SHALL clear on entering WAIT and increment each WAIT cycle.
- On reaching TIMEOUT_CYCLES without set_valid, the FSM SHALL go to RETURN with result=8'hFF and err=1.
- set_valid arriving on the same edge as the timeout SHALL take priority (normal result, err=0).
REQ-033 Macro undefined: no counter is built, WAIT waits indefinitely, and err is tied to 0.

Verification
REQ-034 Reset, then req_a with central=24'h44_00_00, radius=12'h300, mode=0; engine model returns 8'd29 -> ack_a and set_en high 1 cycle later, done_a with result=29, err=0, 1 cycle after set_valid.
REQ-035 req_a and req_b raised on the same cycle with req held, three jobs served -> service order A, B, A, with one ack per job.
REQ-036 set_busy=1 for 5 cycles while req_b=1 -> no ack_b and no set_en until the cycle after set_busy falls.
REQ-037 rst pulsed in WAIT, then set_valid arrives -> no done, all outputs 0, FSM in IDLE; a subsequent req_b is granted normally.
REQ-038 With the macro defined and TIMEOUT_CYCLES=16, engine never asserts valid -> done_a 1 cycle after timeout with result=8'hFF, err=1; the next job completes normally with err=0.
